// File: rtl/slave_serial_port.sv
// Slave side of a select/ACK serial link: grants a frame only when the local
// receive buffer is free, otherwise parks in SPLIT_PEND until it can regrant.
module slave_serial_port #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_rx,
  output logic              s_tx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              split_pend,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int GAP_W = $clog2(GAP + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    GAP_WAIT,
    RECV,
    SPLIT_PEND
  } state_t;

  state_t            state_q, state_d;
  logic              s_tx_q, s_tx_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              split_q, split_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  logic buf_free;
  logic frame_done;

  // A grant is only ever given while the buffer is free, so a frame can never
  // land on top of one the consumer has not taken yet.
  assign buf_free = !rx_valid_q || rx_ready;

  always_comb begin
    state_d    = state_q;
    s_tx_d     = s_tx_q;
    rx_data_d  = rx_data_q;
    split_d    = split_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (!s_rx) begin
          if (buf_free) begin
            state_d = ACK;
            s_tx_d  = 1'b0;
          end else begin
            state_d = SPLIT_PEND;
            split_d = 1'b1;
          end
        end
      end

      SPLIT_PEND: begin
        if (buf_free) begin
          state_d = ACK;
          s_tx_d  = 1'b0;
          split_d = 1'b0;
        end
      end

      ACK: begin
        gap_cnt_d = '0;
        bit_cnt_d = '0;
        shift_d   = '0;
        state_d   = (GAP == 0) ? RECV : GAP_WAIT;
      end

      GAP_WAIT: begin
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = RECV;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      RECV: begin
        // LSB arrives first, so each new bit enters at the top and walks down.
        shift_d = {s_rx, shift_q[DATA_W-1:1]};
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          frame_done = 1'b1;
          rx_data_d  = shift_d;
          s_tx_d     = 1'b1;
          bit_cnt_d  = '0;
          state_d    = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        s_tx_d  = 1'b1;
        split_d = 1'b0;
      end
    endcase

    if (frame_done) begin
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      s_tx_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      split_q    <= 1'b0;
      busy_q     <= 1'b0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      s_tx_q     <= s_tx_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      split_q    <= split_d;
      busy_q     <= busy_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
    end
  end

  assign s_tx       = s_tx_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign split_pend = split_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_slave_serial_port.sv
// Directed bench for slave_serial_port: a transaction-level model of the link
// is checked every cycle, alongside hand-computed expectations per scenario.
module tb_slave_serial_port;

  localparam int DATA_W      = 8;
  localparam int GAP         = 2;
  localparam int FRAME_EDGES = 1 + GAP + DATA_W;

  localparam int MODE_IDLE   = 0;
  localparam int MODE_PEND   = 1;
  localparam int MODE_ACTIVE = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              s_rx = 1'b1;
  logic              rx_ready = 1'b0;
  logic              s_tx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              split_pend;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slave_serial_port #(
    .DATA_W(DATA_W),
    .GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_rx      (s_rx),
    .s_tx      (s_tx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .split_pend(split_pend),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Link model: a grant at edge t0 keeps s_tx low until t0+1+GAP+DATA_W, and
  // data bit k is the s_rx value sampled on edge t0+GAP+2+k.
  int                m_mode = MODE_IDLE;
  int                edge_n = 0;
  int                grant_n = 0;
  logic              m_valid = 1'b0;
  logic              m_split = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  logic [DATA_W-1:0] m_frame = '0;

  always @(posedge clk or negedge rstn) begin
    int   off;
    logic free;
    logic done;
    if (!rstn) begin
      m_mode  = MODE_IDLE;
      m_valid = 1'b0;
      m_split = 1'b0;
      m_data  = '0;
      m_frame = '0;
      edge_n  = 0;
    end else begin
      free = !m_valid || rx_ready;
      done = 1'b0;
      edge_n++;
      if (m_mode == MODE_ACTIVE) begin
        off = edge_n - grant_n;
        if (off >= GAP + 2) m_frame[off - GAP - 2] = s_rx;
        if (off == FRAME_EDGES) begin
          done   = 1'b1;
          m_mode = MODE_IDLE;
        end
      end else if (m_mode == MODE_PEND) begin
        if (free) begin
          m_mode  = MODE_ACTIVE;
          grant_n = edge_n;
          m_split = 1'b0;
          m_frame = '0;
        end
      end else if (!s_rx) begin
        if (free) begin
          m_mode  = MODE_ACTIVE;
          grant_n = edge_n;
          m_frame = '0;
        end else begin
          m_mode  = MODE_PEND;
          m_split = 1'b1;
        end
      end
      if (done) begin
        m_valid = 1'b1;
        m_data  = m_frame;
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      checkOutput("model_s_tx", s_tx, (m_mode == MODE_ACTIVE) ? 0 : 1);
      checkOutput("model_rx_valid", rx_valid, m_valid);
      checkOutput("model_rx_data", rx_data, m_data);
      checkOutput("model_split_pend", split_pend, m_split);
      checkOutput("model_busy", busy, (m_mode != MODE_IDLE) ? 1 : 0);
    end
  end

  // Low-period lengths of s_tx and rising edges of rx_valid.
  int   low_run = 0;
  int   last_low_len = 0;
  int   low_periods = 0;
  int   rises = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      low_run    = 0;
      prev_valid = 1'b0;
    end else begin
      if (!s_tx) begin
        low_run++;
      end else if (low_run > 0) begin
        last_low_len = low_run;
        low_periods++;
        low_run = 0;
      end
      if (rx_valid && !prev_valid) rises++;
      prev_valid = rx_valid;
    end
  end

  logic [DATA_W-1:0] accepted[$];

  always @(posedge clk) begin
    if (rstn && rx_valid && rx_ready) accepted.push_back(rx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sr, input logic rdy);
    s_rx     = sr;
    rx_ready = rdy;
    tick();
  endtask

  // Called right after the grant edge; ends one cycle past the last bit.
  task automatic send_frame(input logic [DATA_W-1:0] data, input logic rdy);
    repeat (1 + GAP) applyStimulus(1'b1, rdy);
    for (int k = 0; k < DATA_W; k++) applyStimulus(data[k], rdy);
    s_rx = 1'b1;
  endtask

  int base_low;
  int base_rises;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] partial;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_s_tx", s_tx, 1);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_split", split_pend, 0);
    checkOutput("reset_busy", busy, 0);
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b0);

    $display("[TB] basic frame 0xA5");
    applyStimulus(1'b0, 1'b0);
    checkOutput("a5_ack_s_tx", s_tx, 0);
    checkOutput("a5_ack_busy", busy, 1);
    send_frame(8'hA5, 1'b0);
    checkOutput("a5_rx_valid", rx_valid, 1);
    checkOutput("a5_rx_data", rx_data, 32'hA5);
    checkOutput("a5_s_tx_release", s_tx, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("a5_low_len", last_low_len, FRAME_EDGES);

    $display("[TB] split then regrant, frame 0x3C");
    applyStimulus(1'b0, 1'b0);
    checkOutput("split_s_tx", s_tx, 1);
    checkOutput("split_flag", split_pend, 1);
    checkOutput("split_busy", busy, 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("split_ignore_s_tx", s_tx, 1);
    checkOutput("split_hold_data", rx_data, 32'hA5);
    applyStimulus(1'b1, 1'b1);
    checkOutput("regrant_s_tx", s_tx, 0);
    checkOutput("regrant_split", split_pend, 0);
    checkOutput("regrant_consumed", rx_valid, 0);
    send_frame(8'h3C, 1'b0);
    checkOutput("3c_rx_valid", rx_valid, 1);
    checkOutput("3c_rx_data", rx_data, 32'h3C);

    $display("[TB] back-to-back 0x01 / 0xFF with ready held");
    applyStimulus(1'b0, 1'b1);
    checkOutput("b2b_grant1", s_tx, 0);
    send_frame(8'h01, 1'b1);
    checkOutput("b2b_01_valid", rx_valid, 1);
    checkOutput("b2b_01_data", rx_data, 32'h01);
    applyStimulus(1'b0, 1'b1);
    checkOutput("b2b_grant2", s_tx, 0);
    send_frame(8'hFF, 1'b1);
    checkOutput("b2b_ff_valid", rx_valid, 1);
    checkOutput("b2b_ff_data", rx_data, 32'hFF);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 1'b1);
    checkOutput("rst_grant", s_tx, 0);
    checkOutput("accepted_count", accepted.size(), 4);
    if (accepted.size() == 4) begin
      checkOutput("accepted_0", accepted[0], 32'hA5);
      checkOutput("accepted_1", accepted[1], 32'h3C);
      checkOutput("accepted_2", accepted[2], 32'h01);
      checkOutput("accepted_3", accepted[3], 32'hFF);
    end
    partial = 8'h96;
    repeat (1 + GAP) applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(partial[k], 1'b0);
    s_rx = partial[4];
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_s_tx", s_tx, 1);
    checkOutput("rst_async_valid", rx_valid, 0);
    checkOutput("rst_async_data", rx_data, 0);
    checkOutput("rst_async_busy", busy, 0);
    s_rx = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_idle_busy", busy, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_reack_s_tx", s_tx, 0);
    send_frame(8'h5A, 1'b0);
    checkOutput("5a_rx_valid", rx_valid, 1);
    checkOutput("5a_rx_data", rx_data, 32'h5A);

    $display("[TB] select and ready together in split pending");
    applyStimulus(1'b0, 1'b0);
    checkOutput("sp2_split", split_pend, 1);
    checkOutput("sp2_s_tx", s_tx, 1);
    applyStimulus(1'b1, 1'b0);
    base_low   = low_periods;
    base_rises = rises;
    applyStimulus(1'b0, 1'b1);
    checkOutput("sp2_grant_s_tx", s_tx, 0);
    checkOutput("sp2_grant_split", split_pend, 0);
    checkOutput("sp2_consumed", rx_valid, 0);
    send_frame(8'hC3, 1'b0);
    checkOutput("c3_rx_valid", rx_valid, 1);
    checkOutput("c3_rx_data", rx_data, 32'hC3);
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("sp2_low_periods", low_periods - base_low, 1);
    checkOutput("sp2_low_len", last_low_len, FRAME_EDGES);
    checkOutput("sp2_frames", rises - base_rises, 1);
    checkOutput("sp2_final_s_tx", s_tx, 1);
    checkOutput("sp2_final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
